// File: rtl/shapool_pkg.sv
// Shared widths, state encodings and debug view for the shapool host controller.
package shapool_pkg;

  localparam int JOB_CONFIG_WIDTH    = 360;
  localparam int DEVICE_CONFIG_WIDTH = 8;
  localparam int RESULT_DATA_WIDTH   = 32;
  localparam int LEN_W               = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_JOB,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    SP_IDLE,
    SP_LEAD,
    SP_HIGH,
    SP_LOW,
    SP_TAIL,
    SP_GAP
  } spi_phase_t;

  typedef struct packed {
    state_t     state;
    spi_phase_t bc_phase;
    spi_phase_t dy_phase;
  } dbg_t;

endpackage

// File: rtl/spi_shift_master.sv
// Mode-0 MSB-first SPI frame engine: cs_n framing, SCK divider, shift-out and shift-in.
module spi_shift_master
  import shapool_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_sdi,
  output logic              o_sck,
  output logic              o_sdo,
  output logic              o_cs_n,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output spi_phase_t        o_phase
);

  // Handshake: i_start is a one-cycle pulse honoured only in SP_IDLE, with i_data
  // (left-aligned) and i_len valid in that cycle; o_done pulses once after the
  // cs_n-high gap, when o_rdata holds the last i_len received bits in its LSBs.
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  spi_phase_t        r_phase;
  logic [15:0]       r_div;
  logic [LEN_W-1:0]  r_bits;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx;
  logic              r_sck;
  logic              r_sdo;
  logic              r_cs_n;
  logic              r_done;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_phase <= SP_IDLE;
      r_div   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_sck   <= 1'b0;
      r_sdo   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_phase <= SP_IDLE;
        r_div   <= '0;
        r_sck   <= 1'b0;
        r_sdo   <= 1'b0;
        r_cs_n  <= 1'b1;
      end else begin
        case (r_phase)
          SP_IDLE: begin
            if (i_start) begin
              r_cs_n  <= 1'b0;
              r_shift <= i_data;
              r_sdo   <= i_data[DATA_W-1];
              r_bits  <= i_len;
              r_div   <= '0;
              r_phase <= SP_LEAD;
            end
          end
          default: begin
            if (r_div != DIV_LAST) begin
              r_div <= r_div + 16'd1;
            end else begin
              r_div <= '0;
              case (r_phase)
                SP_LEAD, SP_LOW: begin
                  // Sample on the rising edge; the slave drove this bit while SCK was low.
                  r_sck   <= 1'b1;
                  r_rx    <= {r_rx[DATA_W-2:0], i_sdi};
                  r_phase <= SP_HIGH;
                end
                SP_HIGH: begin
                  r_sck  <= 1'b0;
                  r_bits <= r_bits - LEN_W'(1);
                  if (r_bits == LEN_W'(1)) begin
                    r_phase <= SP_TAIL;
                  end else begin
                    r_shift <= r_shift << 1;
                    r_sdo   <= r_shift[DATA_W-2];
                    r_phase <= SP_LOW;
                  end
                end
                SP_TAIL: begin
                  r_cs_n  <= 1'b1;
                  r_sdo   <= 1'b0;
                  r_phase <= SP_GAP;
                end
                SP_GAP: begin
                  r_done  <= 1'b1;
                  r_phase <= SP_IDLE;
                end
                default: r_phase <= SP_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign o_sck   = r_sck;
  assign o_sdo   = r_sdo;
  assign o_cs_n  = r_cs_n;
  assign o_done  = r_done;
  assign o_rdata = r_rx;
  assign o_phase = r_phase;

endmodule

// File: rtl/shapool_host.sv
// Host sequencer: configures a daisy chain of hashing devices, broadcasts a job,
// waits for READY and reads back one nonce per device.
module shapool_host
  import shapool_pkg::*;
#(
  parameter int          NUM_DEVICES  = 1,
  parameter int          CLK_DIV      = 4,
  parameter logic [31:0] WAIT_TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic                                       clk_in,
  input  logic                                       reset_in,
  input  logic                                       start_in,
  input  logic                                       abort_in,
  input  logic [NUM_DEVICES*DEVICE_CONFIG_WIDTH-1:0] device_config_in,
  input  logic [JOB_CONFIG_WIDTH-1:0]                job_config_in,
  output logic                                       sck0_out,
  output logic                                       sdo0_out,
  output logic                                       cs0_n_out,
  output logic                                       sck1_out,
  output logic                                       sdo1_out,
  output logic                                       cs1_n_out,
  input  logic                                       sdi1_in,
  input  logic                                       ready_n_in,
  output logic                                       busy_out,
  output logic                                       done_out,
  output logic                                       timeout_out,
  output logic [NUM_DEVICES*RESULT_DATA_WIDTH-1:0]   result_out,
  output dbg_t                                       dbg_out
);

  localparam int DCW = NUM_DEVICES * DEVICE_CONFIG_WIDTH;
  localparam int RW  = NUM_DEVICES * RESULT_DATA_WIDTH;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_entered;
  logic                        r_sync1;
  logic                        r_sync2;
  logic [DCW-1:0]              r_dev_cfg;
  logic [JOB_CONFIG_WIDTH-1:0] r_job_cfg;
  logic [RW-1:0]               r_result;
  logic                        r_timeout;
  logic [31:0]                 r_wait_cnt;

  logic                        w_ready;
  logic                        w_abort;
  logic                        w_bc_start;
  logic                        w_dy_start;
  logic                        w_bc_done;
  logic                        w_dy_done;
  logic [RW-1:0]               w_dy_data;
  logic [LEN_W-1:0]            w_dy_len;
  logic [RW-1:0]               w_dy_rdata;
  logic [JOB_CONFIG_WIDTH-1:0] w_bc_rdata_unused;
  spi_phase_t                  w_bc_phase;
  spi_phase_t                  w_dy_phase;

  assign w_ready = ~r_sync2;
  // DONE is excluded: the job has already ended there.
  assign w_abort = abort_in && (r_state != ST_IDLE) && (r_state != ST_DONE);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      r_entered <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_entered <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next   = r_state;
    busy_out = (r_state != ST_IDLE);
    done_out = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: if (start_in) w_next = ST_CFG;
      ST_CFG:  if (w_dy_done) w_next = ST_JOB;
      ST_JOB:  if (w_bc_done) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_ready) w_next = ST_READ;
        else if (r_wait_cnt == WAIT_TIMEOUT) w_next = ST_DONE;
      end
      ST_READ: if (w_dy_done) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_DONE;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ready_n_in;
      r_sync2 <= r_sync1;
    end
  end

  // r_wait_cnt equals the number of WAIT cycles elapsed, including the current one.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_dev_cfg  <= '0;
      r_job_cfg  <= '0;
      r_result   <= '0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= 32'd1;
    end else begin
      if (r_state == ST_IDLE && start_in) begin
        r_dev_cfg <= device_config_in;
        r_job_cfg <= job_config_in;
      end
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 32'd1 : 32'd1;
      if (w_next == ST_DONE && r_state != ST_DONE) begin
        if (r_state == ST_READ && !w_abort) begin
          r_result  <= w_dy_rdata;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_bc_start = r_entered && (r_state == ST_JOB);
    w_dy_start = r_entered && (r_state == ST_CFG || r_state == ST_READ);
    w_dy_data  = '0;
    w_dy_len   = LEN_W'(RW);
    if (r_state == ST_CFG) begin
      w_dy_data = {r_dev_cfg, {(RW - DCW){1'b0}}};
      w_dy_len  = LEN_W'(DCW);
    end
  end

  spi_shift_master #(
    .DATA_W  (JOB_CONFIG_WIDTH),
    .CLK_DIV (CLK_DIV)
  ) u_bcast (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_start  (w_bc_start),
    .i_abort  (w_abort),
    .i_data   (r_job_cfg),
    .i_len    (LEN_W'(JOB_CONFIG_WIDTH)),
    .i_sdi    (1'b0),
    .o_sck    (sck0_out),
    .o_sdo    (sdo0_out),
    .o_cs_n   (cs0_n_out),
    .o_done   (w_bc_done),
    .o_rdata  (w_bc_rdata_unused),
    .o_phase  (w_bc_phase)
  );

  spi_shift_master #(
    .DATA_W  (RW),
    .CLK_DIV (CLK_DIV)
  ) u_daisy (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_start  (w_dy_start),
    .i_abort  (w_abort),
    .i_data   (w_dy_data),
    .i_len    (w_dy_len),
    .i_sdi    (sdi1_in),
    .o_sck    (sck1_out),
    .o_sdo    (sdo1_out),
    .o_cs_n   (cs1_n_out),
    .o_done   (w_dy_done),
    .o_rdata  (w_dy_rdata),
    .o_phase  (w_dy_phase)
  );

  assign timeout_out       = r_timeout;
  assign result_out        = r_result;
  assign dbg_out.state     = r_state;
  assign dbg_out.bc_phase  = w_bc_phase;
  assign dbg_out.dy_phase  = w_dy_phase;

endmodule

// File: tb/tb_shapool_host.sv
// Bench for shapool_host: two-device daisy-chain model, scoreboard on done_out,
// plus a second instance with a short READY timeout.
module tb_shapool_host;
  import shapool_pkg::*;

  localparam int ND = 2;
  localparam int CD = 2;
  localparam logic [359:0] JOB_A = {256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
                                    96'hDEADBEEFCAFEBABE01234567, 8'h1F};
  localparam logic [359:0] JOB_B = {256'h0123456789ABCDEFFEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0,
                                    96'h00112233445566778899AABB, 8'h42};
  localparam logic [63:0] READ_WORDS = 64'hDEADBEEF_12345678;

  // clock / reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic reset_in = 1'b1;

  // main DUT signals
  logic         start_in = 1'b0, abort_in = 1'b0, sdi1_in = 1'b0, ready_n_in = 1'b1;
  logic [15:0]  device_config_in = '0;
  logic [359:0] job_config_in = '0;
  logic         sck0_out, sdo0_out, cs0_n_out, sck1_out, sdo1_out, cs1_n_out;
  logic         busy_out, done_out, timeout_out;
  logic [63:0]  result_out;
  dbg_t         dbg;

  // timeout DUT signals
  logic         to_start = 1'b0, to_abort = 1'b0, to_sdi = 1'b0, to_ready_n = 1'b1;
  logic         to_sck0, to_sdo0, to_cs0_n, to_sck1, to_sdo1, to_cs1_n;
  logic         to_busy, to_done, to_timeout;
  logic [63:0]  to_result;
  dbg_t         to_dbg;

  shapool_host #(.NUM_DEVICES(ND), .CLK_DIV(CD), .WAIT_TIMEOUT(32'd1000)) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
    .device_config_in(device_config_in), .job_config_in(job_config_in),
    .sck0_out(sck0_out), .sdo0_out(sdo0_out), .cs0_n_out(cs0_n_out),
    .sck1_out(sck1_out), .sdo1_out(sdo1_out), .cs1_n_out(cs1_n_out),
    .sdi1_in(sdi1_in), .ready_n_in(ready_n_in),
    .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out),
    .result_out(result_out), .dbg_out(dbg)
  );

  shapool_host #(.NUM_DEVICES(ND), .CLK_DIV(CD), .WAIT_TIMEOUT(32'd50)) u_to (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(to_start), .abort_in(to_abort),
    .device_config_in(device_config_in), .job_config_in(job_config_in),
    .sck0_out(to_sck0), .sdo0_out(to_sdo0), .cs0_n_out(to_cs0_n),
    .sck1_out(to_sck1), .sdo1_out(to_sdo1), .cs1_n_out(to_cs1_n),
    .sdi1_in(to_sdi), .ready_n_in(to_ready_n),
    .busy_out(to_busy), .done_out(to_done), .timeout_out(to_timeout),
    .result_out(to_result), .dbg_out(to_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // device models on the main DUT
  int           job_bits = 0, cfg_bits = 0, read_bits = 0, lead_cycles = 0, sck_edges = 0;
  int           to_cs1_frames = 0, to_wait_cycles = 0;
  logic [359:0] job_rx = '0;
  logic [15:0]  cfg_rx = '0;
  logic [63:0]  rd_sr = '0;
  logic         rd_mode = 1'b0;
  time          t_cs0_fall = 0;

  always @(negedge cs0_n_out) begin
    job_bits   = 0;
    t_cs0_fall = $time;
  end

  always @(posedge sck0_out) if (!cs0_n_out) begin
    if (job_bits == 0) lead_cycles = int'(($time - t_cs0_fall) / 10);
    job_rx   = {job_rx[358:0], sdo0_out};
    job_bits = job_bits + 1;
  end

  always @(negedge cs1_n_out) begin
    if (ready_n_in == 1'b0) begin
      rd_mode   = 1'b1;
      rd_sr     = READ_WORDS;
      sdi1_in   = rd_sr[63];
      read_bits = 0;
    end else begin
      rd_mode  = 1'b0;
      cfg_bits = 0;
    end
  end

  always @(posedge sck1_out) if (!cs1_n_out) begin
    if (rd_mode) read_bits = read_bits + 1;
    else begin
      cfg_rx   = {cfg_rx[14:0], sdo1_out};
      cfg_bits = cfg_bits + 1;
    end
  end

  always @(negedge sck1_out) if (!cs1_n_out && rd_mode) begin
    rd_sr   = rd_sr << 1;
    sdi1_in = rd_sr[63];
  end

  always @(posedge sck0_out or posedge sck1_out) sck_edges = sck_edges + 1;
  always @(negedge to_cs1_n) to_cs1_frames = to_cs1_frames + 1;
  always @(negedge clk_in) if (to_dbg.state == ST_WAIT) to_wait_cycles = to_wait_cycles + 1;

  // scoreboard: {timeout, result} expected per done pulse
  logic [64:0] exp_q[$];
  logic [64:0] exp_to_q[$];
  logic        prev_done = 1'b0, prev_to_done = 1'b0;
  int          n_done = 0;

  always @(negedge clk_in) begin : monitor
    logic [64:0] e;
    if (done_out) begin
      n_done = n_done + 1;
      check("done_width", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        check("result_out", result_out, e[63:0]);
        check("timeout_out", 64'(timeout_out), 64'(e[64]));
      end
    end
    if (to_done) begin
      if (exp_to_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL to_done_unexpected: got done pulse, expected none");
      end else begin
        e = exp_to_q.pop_front();
        check("to_result_out", to_result, e[63:0]);
        check("to_timeout_out", 64'(to_timeout), 64'(e[64]));
      end
    end
    prev_done    = done_out;
    prev_to_done = to_done;
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int k;
    k = 0;
    while (dbg.state != s && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= budget) bound_fail(name);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cs0_n"}, 64'(cs0_n_out), 64'd1);
    check({tag, "_cs1_n"}, 64'(cs1_n_out), 64'd1);
    check({tag, "_sck"}, 64'({sck0_out, sck1_out}), 64'd0);
    check({tag, "_sdo"}, 64'({sdo0_out, sdo1_out}), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_timeout"}, 64'(timeout_out), 64'd0);
    check({tag, "_result"}, result_out, 64'd0);
    check({tag, "_state"}, 64'(dbg.state), 64'(ST_IDLE));
  endtask

  task automatic run_full_job(input logic [15:0] dcfg, input logic [359:0] jcfg);
    int k;
    device_config_in = dcfg;
    job_config_in    = jcfg;
    exp_q.push_back({1'b0, READ_WORDS});
    pulse_start();
    device_config_in = ~dcfg;
    job_config_in    = ~jcfg;
    wait_state(ST_JOB, 500, "reach_job");
    repeat (20) @(negedge clk_in);
    pulse_start();
    check("start_ignored_job", 64'(dbg.state), 64'(ST_JOB));
    wait_state(ST_WAIT, 3000, "reach_wait");
    repeat (100) @(negedge clk_in);
    ready_n_in = 1'b0;
    k = 0;
    while (!done_out && k < 2000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 2000) bound_fail("job_done");
    ready_n_in = 1'b1;
    check("cfg_bits", 64'(cfg_bits), 64'd16);
    check("nonce_last_dev", 64'(cfg_rx[15:8]), 64'(dcfg[15:8]));
    check("nonce_first_dev", 64'(cfg_rx[7:0]), 64'(dcfg[7:0]));
    check("job_bits", 64'(job_bits), 64'd360);
    check("job_payload", 64'(job_rx == jcfg), 64'd1);
    check("read_bits", 64'(read_bits), 64'd64);
    check("sck_lead", 64'(lead_cycles), 64'(CD));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    int edges_before;
    repeat (3) @(negedge clk_in);
    check_reset("rst");
    check("to_rst_result", to_result, 64'd0);
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // normal job, nonce_start 00 (last device) / 80 (first device)
    run_full_job(16'h0080, JOB_A);
    repeat (30) @(negedge clk_in);
    check("done_count_1", 64'(n_done), 64'd1);
    check("busy_after_job", 64'(busy_out), 64'd0);

    // READY never arrives on the short-timeout instance
    exp_to_q.push_back({1'b1, 64'd0});
    @(negedge clk_in);
    to_start = 1'b1;
    @(negedge clk_in);
    to_start = 1'b0;
    k = 0;
    while (!to_done && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 3000) bound_fail("to_done");
    check("to_wait_cycles", 64'(to_wait_cycles), 64'd50);
    check("to_no_read_xfer", 64'(to_cs1_frames), 64'd1);
    @(negedge clk_in);
    check("to_busy_after", 64'(to_busy), 64'd0);

    // abort in the middle of the broadcast, result must be kept
    exp_q.push_back({1'b1, READ_WORDS});
    device_config_in = 16'h1234;
    job_config_in    = JOB_B;
    pulse_start();
    repeat (10) @(negedge clk_in);
    pulse_start();
    check("start_ignored_cfg", 64'(dbg.state), 64'(ST_CFG));
    wait_state(ST_JOB, 500, "abort_reach_job");
    k = 0;
    while (job_bits != 200 && k < 2000) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 2000) bound_fail("abort_bit200");
    abort_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("abort_cs0_n", 64'(cs0_n_out), 64'd1);
    check("abort_sck0", 64'(sck0_out), 64'd0);
    check("abort_state", 64'(dbg.state), 64'(ST_DONE));
    check("abort_done", 64'(done_out), 64'd1);
    abort_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("abort_busy_after", 64'(busy_out), 64'd0);

    // reset in the middle of the read-back
    device_config_in = 16'h0080;
    job_config_in    = JOB_A;
    exp_q.push_back({1'b0, READ_WORDS});
    pulse_start();
    wait_state(ST_WAIT, 3000, "rr_reach_wait");
    repeat (5) @(negedge clk_in);
    ready_n_in = 1'b0;
    wait_state(ST_READ, 50, "rr_reach_read");
    k = 0;
    while (read_bits < 20 && k < 500) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 500) bound_fail("rr_read_bits");
    reset_in = 1'b1;
    #1;
    check_reset("rst_mid_read");
    exp_q.delete();
    ready_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    edges_before = sck_edges;
    repeat (20) @(negedge clk_in);
    check("no_sck_after_reset", 64'(sck_edges - edges_before), 64'd0);

    run_full_job(16'h0080, JOB_B);
    repeat (30) @(negedge clk_in);
    check("done_count_total", 64'(n_done), 64'd3);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_to_q_drained", 64'(exp_to_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
